perf_event_gen: RTL and testbench

Upstream event source for the machine performance counters. Turns raw retire, memory-access and trap information from the core into the single-cycle event pulses carried on the `EVENT_INT` event bus, which the counter block counts. A small memory-tracking FSM attributes unaligned accesses to completed accesses and bounds stuck accesses with a timeout.

---
 rtl/perf_event_gen_if.sv | 22 ++
 rtl/perf_event_gen.sv | 142 ++++++++++++++
 tb/tb_perf_event_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/perf_event_gen_if.sv
// Event bus carrying one-cycle performance-counter event pulses.
interface EVENT_INT;
    logic execute;
    logic load;
    logic store;
    logic unaligned;
    logic arithmetic;
    logic trap;
    logic interrupt;
    logic unconditional_branch;
    logic conditional_branch;
    logic branch;

    modport out (
        output execute, load, store, unaligned, arithmetic,
               trap, interrupt, unconditional_branch, conditional_branch, branch
    );
    modport in (
        input  execute, load, store, unaligned, arithmetic,
               trap, interrupt, unconditional_branch, conditional_branch, branch
    );
endinterface

// File: rtl/perf_event_gen.sv
// Converts retire, memory-access and trap activity into registered one-cycle
// event pulses for the performance counters.
module perf_event_gen #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       retire_valid,
    input  logic [2:0] retire_class,
    input  logic       branch_taken,
    input  logic       mem_req,
    input  logic [1:0] mem_addr_lo,
    input  logic [1:0] mem_size,
    input  logic       mem_ack,
    input  logic       trap_taken,
    input  logic       trap_is_interrupt,
    input  logic       flush,
    EVENT_INT.out      event_bus,
    output logic       mem_timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unaligned_d;
    logic             timeout_d;
    logic             misaligned;
    logic             retire_ok;
    logic             is_jump;
    logic             is_cond;

    // An exception suppresses the retire; an interrupt does not.
    assign retire_ok = retire_valid & ~(trap_taken & ~trap_is_interrupt);
    assign is_jump   = (retire_class == 3'd4);
    assign is_cond   = (retire_class == 3'd5);

    // Alignment check of the access presented this cycle.
    always_comb begin
        misaligned = 1'b0;
        case (mem_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = mem_addr_lo[0];
            default: misaligned = |mem_addr_lo;
        endcase
    end

    // Memory-tracking FSM next state; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        mis_d       = mis_q;
        cnt_d       = cnt_q;
        unaligned_d = 1'b0;
        timeout_d   = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            mis_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req) begin
                        if (mem_ack) begin
                            unaligned_d = misaligned;
                        end else begin
                            state_d = ST_WAIT;
                            mis_d   = misaligned;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        state_d     = ST_IDLE;
                        unaligned_d = mis_q;
                        mis_d       = 1'b0;
                        cnt_d       = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        mis_d     = 1'b0;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    mis_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered event pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            event_bus.execute              <= 1'b0;
            event_bus.load                 <= 1'b0;
            event_bus.store                <= 1'b0;
            event_bus.unaligned            <= 1'b0;
            event_bus.arithmetic           <= 1'b0;
            event_bus.trap                 <= 1'b0;
            event_bus.interrupt            <= 1'b0;
            event_bus.unconditional_branch <= 1'b0;
            event_bus.conditional_branch   <= 1'b0;
            event_bus.branch               <= 1'b0;
            mem_timeout                    <= 1'b0;
        end else begin
            event_bus.execute              <= retire_ok;
            event_bus.load                 <= retire_ok & (retire_class == 3'd1);
            event_bus.store                <= retire_ok & (retire_class == 3'd2);
            event_bus.unaligned            <= unaligned_d;
            event_bus.arithmetic           <= retire_ok & (retire_class == 3'd3);
            event_bus.trap                 <= trap_taken;
            event_bus.interrupt            <= trap_taken & trap_is_interrupt;
            event_bus.unconditional_branch <= retire_ok & is_jump;
            event_bus.conditional_branch   <= retire_ok & is_cond;
            event_bus.branch               <= retire_ok & (is_jump | is_cond) & branch_taken;
            mem_timeout                    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_perf_event_gen.sv
// Directed self-checking bench for perf_event_gen with a short access timeout.
module tb_perf_event_gen;

    localparam int unsigned TMO = 4;

    localparam logic [10:0] EXE = 11'b100_0000_0000;
    localparam logic [10:0] LD  = 11'b010_0000_0000;
    localparam logic [10:0] ST  = 11'b001_0000_0000;
    localparam logic [10:0] UNA = 11'b000_1000_0000;
    localparam logic [10:0] ARI = 11'b000_0100_0000;
    localparam logic [10:0] TRP = 11'b000_0010_0000;
    localparam logic [10:0] INT = 11'b000_0001_0000;
    localparam logic [10:0] UB  = 11'b000_0000_1000;
    localparam logic [10:0] CB  = 11'b000_0000_0100;
    localparam logic [10:0] BR  = 11'b000_0000_0010;
    localparam logic [10:0] TMT = 11'b000_0000_0001;
    localparam logic [10:0] NONE = 11'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       retire_valid;
    logic [2:0] retire_class;
    logic       branch_taken;
    logic       mem_req;
    logic [1:0] mem_addr_lo;
    logic [1:0] mem_size;
    logic       mem_ack;
    logic       trap_taken;
    logic       trap_is_interrupt;
    logic       flush;
    logic       mem_timeout;
    logic [10:0] obs;

    int errors = 0;
    int checks = 0;

    EVENT_INT ev ();

    perf_event_gen #(.MEM_TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .retire_valid      (retire_valid),
        .retire_class      (retire_class),
        .branch_taken      (branch_taken),
        .mem_req           (mem_req),
        .mem_addr_lo       (mem_addr_lo),
        .mem_size          (mem_size),
        .mem_ack           (mem_ack),
        .trap_taken        (trap_taken),
        .trap_is_interrupt (trap_is_interrupt),
        .flush             (flush),
        .event_bus         (ev),
        .mem_timeout       (mem_timeout)
    );

    always #5 clk = ~clk;

    assign obs = {ev.execute, ev.load, ev.store, ev.unaligned, ev.arithmetic,
                  ev.trap, ev.interrupt, ev.unconditional_branch,
                  ev.conditional_branch, ev.branch, mem_timeout};

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic v, input logic [2:0] cls, input logic tk);
        retire_valid = v;
        retire_class = cls;
        branch_taken = tk;
    endtask

    task automatic access(input logic rq, input logic [1:0] sz, input logic [1:0] a, input logic ak);
        mem_req     = rq;
        mem_size    = sz;
        mem_addr_lo = a;
        mem_ack     = ak;
    endtask

    initial begin
        rst = 1'b0;
        retire(1'b0, 3'd0, 1'b0);
        access(1'b0, 2'd0, 2'd0, 1'b0);
        trap_taken = 1'b0;
        trap_is_interrupt = 1'b0;
        flush = 1'b0;

        tick();
        check("reset_hold", obs, NONE);
        tick();
        rst = 1'b1;
        tick();
        check("after_release", obs, NONE);

        // Misaligned word goes to WAIT alongside a retire, then reset mid-access.
        retire(1'b1, 3'd3, 1'b0);
        access(1'b1, 2'd2, 2'd2, 1'b0);
        tick();
        check("pre_reset_retire", obs, EXE | ARI);
        access(1'b0, 2'd0, 2'd0, 1'b0);
        tick();
        check("wait_retire", obs, EXE | ARI);
        #2 rst = 1'b0;
        #1 check("async_clear", obs, NONE);
        tick();
        check("reset_mid_wait", obs, NONE);
        #2 rst = 1'b1;
        retire(1'b0, 3'd0, 1'b0);
        access(1'b0, 2'd0, 2'd0, 1'b1);
        tick();
        check("ack_after_reset", obs, NONE);
        access(1'b0, 2'd0, 2'd0, 1'b0);

        // Back-to-back retire mix.
        retire(1'b1, 3'd1, 1'b0); tick(); check("mix_load", obs, EXE | LD);
        retire(1'b1, 3'd2, 1'b0); tick(); check("mix_store", obs, EXE | ST);
        retire(1'b1, 3'd3, 1'b0); tick(); check("mix_arith", obs, EXE | ARI);
        retire(1'b1, 3'd4, 1'b1); tick(); check("mix_jal_taken", obs, EXE | UB | BR);
        retire(1'b1, 3'd5, 1'b0); tick(); check("mix_cond_nt", obs, EXE | CB);
        retire(1'b1, 3'd0, 1'b1); tick(); check("mix_other", obs, EXE);
        retire(1'b1, 3'd5, 1'b1); tick(); check("mix_cond_taken", obs, EXE | CB | BR);
        retire(1'b1, 3'd7, 1'b1); tick(); check("mix_class7", obs, EXE);
        retire(1'b0, 3'd1, 1'b1); tick(); check("no_retire", obs, NONE);

        // Exception suppresses the retire; an interrupt does not.
        retire(1'b1, 3'd1, 1'b0);
        trap_taken = 1'b1; trap_is_interrupt = 1'b0;
        tick(); check("exception", obs, TRP);
        trap_is_interrupt = 1'b1;
        tick(); check("interrupt", obs, TRP | INT | EXE | LD);
        retire(1'b0, 3'd0, 1'b0);
        trap_taken = 1'b0; trap_is_interrupt = 1'b0;
        tick(); check("trap_idle", obs, NONE);

        // Zero-wait alignment cases.
        access(1'b1, 2'd1, 2'd1, 1'b1); tick(); check("half_a1", obs, UNA);
        access(1'b1, 2'd1, 2'd2, 1'b1); tick(); check("half_a2", obs, NONE);
        access(1'b1, 2'd0, 2'd3, 1'b1); tick(); check("byte_a3", obs, NONE);
        access(1'b1, 2'd3, 2'd1, 1'b1); tick(); check("size3_a1", obs, UNA);
        access(1'b1, 2'd2, 2'd0, 1'b1); tick(); check("word_a0", obs, NONE);
        access(1'b0, 2'd1, 2'd1, 1'b1); tick(); check("ack_no_req", obs, NONE);

        // Word at addr 2, ack three cycles later.
        access(1'b1, 2'd2, 2'd2, 1'b0); tick(); check("word_wait0", obs, NONE);
        access(1'b0, 2'd0, 2'd0, 1'b0); tick(); check("word_wait1", obs, NONE);
        tick(); check("word_wait2", obs, NONE);
        mem_ack = 1'b1; tick(); check("word_late_ack", obs, UNA);
        mem_ack = 1'b0; tick(); check("word_after", obs, NONE);

        // New request during the completing ack is ignored.
        access(1'b1, 2'd2, 2'd0, 1'b0); tick(); check("aligned_wait", obs, NONE);
        access(1'b1, 2'd2, 2'd3, 1'b1); tick(); check("ack_ignores_req", obs, NONE);
        access(1'b0, 2'd2, 2'd3, 1'b1); tick(); check("no_second_access", obs, NONE);

        // Timeout: request at cycle 0, pulse visible at cycle TMO+1.
        access(1'b1, 2'd2, 2'd1, 1'b0); tick(); check("tmo_c1", obs, NONE);
        access(1'b0, 2'd0, 2'd0, 1'b0);
        for (int i = 2; i <= int'(TMO); i++) begin
            tick();
            check($sformatf("tmo_c%0d", i), obs, NONE);
        end
        tick(); check("tmo_pulse", obs, TMT);
        mem_ack = 1'b1; tick(); check("tmo_late_ack", obs, NONE);
        mem_ack = 1'b0; tick(); check("tmo_after", obs, NONE);

        // Flush with ack in WAIT; retire still reported that cycle.
        access(1'b1, 2'd2, 2'd1, 1'b0); tick(); check("fl_issue", obs, NONE);
        access(1'b0, 2'd0, 2'd0, 1'b0); tick(); check("fl_wait", obs, NONE);
        flush = 1'b1; mem_ack = 1'b1;
        retire(1'b1, 3'd3, 1'b0);
        tick(); check("flush_ack", obs, EXE | ARI);
        flush = 1'b0;
        retire(1'b0, 3'd0, 1'b0);
        access(1'b1, 2'd2, 2'd0, 1'b1); tick(); check("post_flush_aligned", obs, NONE);
        access(1'b0, 2'd0, 2'd0, 1'b0);
        for (int i = 0; i < int'(TMO) + 2; i++) begin
            tick();
            check("post_flush_quiet", obs, NONE);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
